// File: rtl/ps2_key_tx.sv
// PS/2 device-side keyboard emulator: serialises one scan-code byte per handshake onto kclk/kdata.
// Define PS2_KEY_TX_BREAK_EN to prefix released keys with an 0xF0 break frame.
module ps2_key_tx #(
    parameter int HALF_PERIOD = 5,
    parameter int GAP         = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_release,
    output logic       tx_ready,
    output logic       busy,
    output logic       kclk,
    output logic       kdata
);

    localparam int PW = $clog2(2 * HALF_PERIOD);
    localparam int GW = $clog2(GAP + 1);
    localparam logic [PW-1:0] PH_FALL  = PW'(HALF_PERIOD);
    localparam logic [PW-1:0] PH_LAST  = PW'(2 * HALF_PERIOD - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP);
    localparam logic [3:0]    BIT_LAST = 4'd10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t          state_q, state_d;
    logic [10:0]     frame_q, frame_d;
    logic [3:0]      bit_q, bit_d;
    logic [PW-1:0]   phase_q, phase_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic            kclk_q, kclk_d;
    logic            kdata_q, kdata_d;
    logic            busy_q, busy_d;
    logic            ready_q, ready_d;

`ifdef PS2_KEY_TX_BREAK_EN
    logic            pending_q, pending_d;
    logic [7:0]      held_q, held_d;
`else
    logic            unused_release;
    assign unused_release = tx_release;
`endif

    // Frame bit order as transmitted: index 0 is the start bit, index 10 the stop bit.
    function automatic logic [10:0] make_frame(input logic [7:0] b);
        return {1'b1, ~^b, b, 1'b0};
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            frame_q   <= '0;
            bit_q     <= '0;
            phase_q   <= '0;
            gap_q     <= '0;
            kclk_q    <= 1'b1;
            kdata_q   <= 1'b1;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
`ifdef PS2_KEY_TX_BREAK_EN
            pending_q <= 1'b0;
            held_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            bit_q     <= bit_d;
            phase_q   <= phase_d;
            gap_q     <= gap_d;
            kclk_q    <= kclk_d;
            kdata_q   <= kdata_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
`ifdef PS2_KEY_TX_BREAK_EN
            pending_q <= pending_d;
            held_q    <= held_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        bit_d     = bit_q;
        phase_d   = phase_q;
        gap_d     = gap_q;
        kclk_d    = kclk_q;
        kdata_d   = kdata_q;
        busy_d    = busy_q;
        ready_d   = ready_q;
`ifdef PS2_KEY_TX_BREAK_EN
        pending_d = pending_q;
        held_d    = held_q;
`endif

        case (state_q)
            S_IDLE: begin
                kclk_d  = 1'b1;
                kdata_d = 1'b1;
                busy_d  = 1'b0;
                ready_d = 1'b1;
                if (tx_valid && ready_q) begin
`ifdef PS2_KEY_TX_BREAK_EN
                    if (tx_release) begin
                        frame_d   = make_frame(8'hF0);
                        held_d    = tx_data;
                        pending_d = 1'b1;
                    end else begin
                        frame_d   = make_frame(tx_data);
                        pending_d = 1'b0;
                    end
`else
                    frame_d = make_frame(tx_data);
`endif
                    state_d = S_SHIFT;
                    bit_d   = '0;
                    phase_d = '0;
                    busy_d  = 1'b1;
                    ready_d = 1'b0;
                end
            end

            // Data is presented at the start of the high phase so it has settled
            // for a full half-period before the receiver's falling-edge sample.
            S_SHIFT: begin
                phase_d = phase_q + PW'(1);
                if (phase_q == '0) begin
                    kdata_d = frame_q[bit_q];
                end
                if (phase_q == PH_FALL) begin
                    kclk_d = 1'b0;
                end
                if (phase_q == PH_LAST) begin
                    kclk_d  = 1'b1;
                    phase_d = '0;
                    if (bit_q == BIT_LAST) begin
                        state_d = S_GAP;
                        kdata_d = 1'b1;
                        gap_d   = '0;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end

            S_GAP: begin
                kclk_d  = 1'b1;
                kdata_d = 1'b1;
                gap_d   = gap_q + GW'(1);
                if (gap_q == GAP_LAST) begin
                    gap_d = '0;
`ifdef PS2_KEY_TX_BREAK_EN
                    if (pending_q) begin
                        frame_d   = make_frame(held_q);
                        pending_d = 1'b0;
                        state_d   = S_SHIFT;
                        bit_d     = '0;
                        phase_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        ready_d = 1'b1;
                    end
`else
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
`endif
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign tx_ready = ready_q;
    assign busy     = busy_q;
    assign kclk     = kclk_q;
    assign kdata    = kdata_q;

endmodule
